// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the FIFO write-side arbitration logic.
package fifo_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEFAULT_DATA_W    = 8;
    localparam int DEFAULT_MAX_BURST = 4;
    localparam int BEAT_CNT_W        = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req, scanning upward
// from last_id+1 and wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic               found,
    output logic [ID_W-1:0]    index
);

    logic [ID_W-1:0]    cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // cand_idx[gi] is the requester examined at priority position gi
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            localparam logic [ID_W:0] OFFSET = (ID_W+1)'(gi + 1);
            localparam logic [ID_W:0] WRAP   = (ID_W+1)'(NUM_REQ);
            logic [ID_W:0] sum;
            logic [ID_W:0] wrapped;
            assign sum           = {1'b0, last_id} + OFFSET;
            assign wrapped       = (sum >= WRAP) ? (sum - WRAP) : sum;
            assign cand_idx[gi]  = wrapped[ID_W-1:0];
            assign hit[gi]       = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                found = 1'b1;
                index = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter funnelling NUM_REQ valid/ready writers into one
// FIFO write port; a grant lasts up to MAX_BURST beats.
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_W    = DEFAULT_DATA_W,
    parameter  int MAX_BURST = DEFAULT_MAX_BURST,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic                      i_fifo_full,
    output logic                      o_fifo_wr,
    output logic [DATA_W-1:0]         o_fifo_wdata,
    output logic [ID_W-1:0]           o_grant_id,
    output logic                      o_busy
);

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT   = BEAT_CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]       LAST_ID_RST = ID_W'(NUM_REQ - 1);

    arb_state_t            state_reg, state_next;
    logic [ID_W-1:0]       grant_id_reg, grant_id_next;
    logic [ID_W-1:0]       last_id_reg, last_id_next;
    logic [BEAT_CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

    logic [DATA_W-1:0]     req_data_arr [NUM_REQ];
    logic                  pick_found;
    logic [ID_W-1:0]       pick_index;
    logic                  in_grant;
    logic                  sel_valid;
    logic                  last_beat;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req     (i_req_valid),
        .last_id (last_id_reg),
        .found   (pick_found),
        .index   (pick_index)
    );

    // Reset masks the handshake combinationally so a beat in flight is dropped
    assign in_grant  = (state_reg == GRANT) && !i_reset;
    assign sel_valid = i_req_valid[grant_id_reg];
    assign last_beat = (beat_cnt_reg == LAST_BEAT);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_data_arr[gi] = i_req_data[gi*DATA_W +: DATA_W];
            assign o_req_ready[gi]  = in_grant && !i_fifo_full
                                      && (grant_id_reg == ID_W'(gi));
        end
    endgenerate

    assign o_fifo_wr    = in_grant && sel_valid && !i_fifo_full;
    assign o_fifo_wdata = req_data_arr[grant_id_reg];
    assign o_grant_id   = i_reset ? '0 : grant_id_reg;
    assign o_busy       = in_grant;

    always_comb begin
        state_next    = state_reg;
        grant_id_next = grant_id_reg;
        last_id_next  = last_id_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next    = GRANT;
                    grant_id_next = pick_index;
                    beat_cnt_next = '0;
                end
            end
            GRANT: begin
                // A full FIFO freezes everything; the grant is never timed out
                if (!i_fifo_full) begin
                    if (!sel_valid || last_beat) begin
                        state_next   = IDLE;
                        last_id_next = grant_id_reg;
                    end
                    if (sel_valid) begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg    <= IDLE;
            grant_id_reg <= '0;
            last_id_reg  <= LAST_ID_RST;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_id_reg <= grant_id_next;
            last_id_reg  <= last_id_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random stimulus for fifo_wr_arbiter, checked cycle by cycle
// against a requester-queue reference model.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int DEPTH = 512;

    logic              clk = 1'b0;
    logic              i_reset;
    logic [NR-1:0]     i_req_valid;
    logic [NR*DW-1:0]  i_req_data;
    logic [NR-1:0]     o_req_ready;
    logic              i_fifo_full;
    logic              o_fifo_wr;
    logic [DW-1:0]     o_fifo_wdata;
    logic [1:0]        o_grant_id;
    logic              o_busy;

    fifo_wr_arbiter #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .i_req_data   (i_req_data),
        .o_req_ready  (o_req_ready),
        .i_fifo_full  (i_fifo_full),
        .o_fifo_wr    (o_fifo_wr),
        .o_fifo_wdata (o_fifo_wdata),
        .o_grant_id   (o_grant_id),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Per-requester source streams: data still to be sent is mem[rd_ptr..wr_cnt-1]
    logic [7:0] src_mem [NR][DEPTH];
    int         rd_ptr [NR];
    int         wr_cnt [NR];
    bit [NR-1:0] en;

    // Reference model: who holds the grant, who held it last, beats sent so far
    bit m_busy;
    int m_gid;
    int m_last;
    int m_beats;

    int glog[$];
    int dut_wr_cnt;
    bit prev_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_src();
        for (int k = 0; k < NR; k++) begin
            rd_ptr[k] = 0;
            wr_cnt[k] = 0;
        end
        en         = '0;
        glog       = {};
        dut_wr_cnt = 0;
    endtask

    task automatic load(input int k, input int n, input logic [7:0] base);
        for (int j = 0; j < n; j++) begin
            src_mem[k][wr_cnt[k]] = base + 8'(j);
            wr_cnt[k]++;
        end
    endtask

    task automatic load_rand(input int k, input int n);
        for (int j = 0; j < n; j++) begin
            src_mem[k][wr_cnt[k]] = 8'($urandom);
            wr_cnt[k]++;
        end
    endtask

    task automatic step(input bit r, input bit f);
        logic [7:0]    d [NR];
        bit [NR-1:0]   v;
        bit            e_busy;
        int            e_gid;
        logic [NR-1:0] e_rdy;
        bit            e_wr;
        bit            picked;
        int            c;
        for (int k = 0; k < NR; k++) begin
            v[k] = en[k] && (rd_ptr[k] < wr_cnt[k]);
            d[k] = (rd_ptr[k] < wr_cnt[k]) ? src_mem[k][rd_ptr[k]] : 8'h00;
            i_req_data[k*DW +: DW] = d[k];
        end
        i_reset     = r;
        i_fifo_full = f;
        i_req_valid = v;
        #1;
        e_busy = m_busy && !r;
        e_gid  = r ? 0 : m_gid;
        e_wr   = e_busy && v[m_gid] && !f;
        e_rdy  = (e_busy && !f) ? NR'(1 << m_gid) : '0;
        chk("busy",     32'(o_busy),       32'(e_busy));
        chk("grant_id", 32'(o_grant_id),   32'(e_gid));
        chk("ready",    32'(o_req_ready),  32'(e_rdy));
        chk("fifo_wr",  32'(o_fifo_wr),    32'(e_wr));
        chk("wdata",    32'(o_fifo_wdata), 32'(d[m_gid]));
        chk("wr_while_full", 32'(o_fifo_wr && i_fifo_full), 32'(0));
        if (o_fifo_wr) begin
            dut_wr_cnt++;
            $display("wr req=%0d data=%02h full=%0b", o_grant_id, o_fifo_wdata, i_fifo_full);
        end
        if (o_busy && !prev_busy) glog.push_back(int'(o_grant_id));
        prev_busy = o_busy;
        if (r) begin
            m_busy  = 1'b0;
            m_gid   = 0;
            m_last  = NR - 1;
            m_beats = 0;
        end else if (!m_busy) begin
            picked = 1'b0;
            for (int s = 1; s <= NR; s++) begin
                c = (m_last + s) % NR;
                if (!picked && v[c]) begin
                    picked  = 1'b1;
                    m_busy  = 1'b1;
                    m_gid   = c;
                    m_beats = 0;
                end
            end
        end else if (!f) begin
            if (v[m_gid]) begin
                rd_ptr[m_gid]++;
                m_beats++;
                if (m_beats == MB) begin
                    m_busy = 1'b0;
                    m_last = m_gid;
                end
            end else begin
                m_busy = 1'b0;
                m_last = m_gid;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_order(input string tag, input int exp_q[$]);
        chk({tag, "_count"}, 32'(glog.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < glog.size()) chk({tag, "_id"}, 32'(glog[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        i_reset     = 1'b1;
        i_fifo_full = 1'b0;
        i_req_valid = '0;
        i_req_data  = '0;
        m_busy = 1'b0; m_gid = 0; m_last = NR - 1; m_beats = 0;
        prev_busy = 1'b0;
        clear_src();
        @(negedge clk);

        // Single requester 2 with six beats: burst of four, bubble, burst of two
        clear_src();
        load(2, 6, 8'hA0);
        en = 4'b0100;
        step(1, 0);
        step(1, 0);
        for (int i = 0; i < 14; i++) step(0, 0);
        chk("s1_writes", 32'(dut_wr_cnt), 32'd6);
        chk_order("s1_order", '{2, 2});

        // All requesters continuously valid
        clear_src();
        for (int k = 0; k < NR; k++) load(k, 20, 8'(k * 16 + 8'h10));
        en = 4'b1111;
        step(1, 0);
        for (int i = 0; i < 25; i++) step(0, 0);
        chk("s2_writes", 32'(dut_wr_cnt), 32'd20);
        chk_order("s2_order", '{0, 1, 2, 3, 0});

        // Requester 1 stalled by a full FIFO for three cycles after beat 2
        clear_src();
        load(1, 6, 8'hB0);
        en = 4'b0010;
        step(1, 0);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        step(0, 1);
        step(0, 1);
        step(0, 1);
        chk("s3_stalled", 32'(dut_wr_cnt), 32'd2);
        step(0, 0);
        step(0, 0);
        chk("s3_writes", 32'(dut_wr_cnt), 32'd4);
        step(0, 0);
        step(0, 0);
        chk_order("s3_order", '{1, 1});

        // Requester 3 runs dry after two beats while requester 0 waits
        clear_src();
        load(2, 1, 8'hC0);
        load(3, 2, 8'hD0);
        load(0, 4, 8'hE0);
        en = 4'b0100;
        step(1, 0);
        step(0, 0);
        step(0, 0);
        en = 4'b1101;
        for (int i = 0; i < 12; i++) step(0, 0);
        chk("s4_writes", 32'(dut_wr_cnt), 32'd7);
        chk_order("s4_order", '{2, 3, 0});

        // Reset in the middle of a burst to requester 1
        clear_src();
        load(1, 6, 8'h10);
        load(2, 4, 8'h20);
        load(3, 4, 8'h30);
        en = 4'b0010;
        step(1, 0);
        step(0, 0);
        step(0, 0);
        step(1, 0);
        chk("s5_aborted", 32'(dut_wr_cnt), 32'd1);
        en = 4'b1100;
        for (int i = 0; i < 7; i++) step(0, 0);
        chk_order("s5_order", '{1, 2, 3});

        // Random valid, full and occasional reset
        clear_src();
        for (int k = 0; k < NR; k++) load_rand(k, 100);
        step(1, 0);
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NR; k++) en[k] = ($urandom_range(0, 99) < 85);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
